// File: rtl/lap_time_bcd_reader.sv
// Converts the three lap-time words to packed BCD with one shared double-dabble engine.
// Optional BLANK_ZERO_EN replaces leading-zero digits 4 and 3 with 4'hF at store time.
module lap_time_bcd_reader #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refresh,
    input  logic [WIDTH-1:0]      current_lap_time,
    input  logic [WIDTH-1:0]      last_lap_time,
    input  logic [WIDTH-1:0]      best_lap_time,
    output logic [4*DIGITS-1:0]   current_bcd,
    output logic [4*DIGITS-1:0]   last_bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] STORE = 2'd3;

    localparam int unsigned BW = 4 * DIGITS;

    logic [1:0]          state;
    logic [1:0]          chan;
    logic [4:0]          cnt;
    logic [WIDTH-1:0]    bin;
    logic [BW-1:0]       bcd;

    logic [WIDTH-1:0]    sel_in;
    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       store_val;

    always_comb begin
        case (chan)
            2'd0:    sel_in = current_lap_time;
            2'd1:    sel_in = last_lap_time;
            default: sel_in = best_lap_time;
        endcase
    end

    // Add-3 correction on every digit that would overflow past 9 after doubling.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin} << 1;
    end

    always_comb begin
        store_val = bcd;
`ifdef BLANK_ZERO_EN
        if (bcd[BW-1 -: 4] == 4'd0) begin
            store_val[BW-1 -: 4] = 4'hF;
            if (bcd[BW-5 -: 4] == 4'd0) begin
                store_val[BW-5 -: 4] = 4'hF;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            chan        <= 2'd0;
            cnt         <= 5'd0;
            bin         <= '0;
            bcd         <= '0;
            current_bcd <= '0;
            last_bcd    <= '0;
            best_bcd    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (refresh) begin
                        state <= LOAD;
                        chan  <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    bin   <= sel_in;
                    bcd   <= '0;
                    cnt   <= 5'd0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    bcd <= shifted[BW+WIDTH-1:WIDTH];
                    bin <= shifted[WIDTH-1:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(WIDTH - 1)) begin
                        state <= STORE;
                    end
                end
                default: begin
                    case (chan)
                        2'd0:    current_bcd <= store_val;
                        2'd1:    last_bcd    <= store_val;
                        default: best_bcd    <= store_val;
                    endcase
                    if (chan == 2'd2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        chan  <= chan + 2'd1;
                        state <= LOAD;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lap_time_bcd_reader.sv
// Directed bench for lap_time_bcd_reader; expected BCD values are hand-computed constants.
// Define BLANK_ZERO_EN here as well as in the RTL to check the blanking build.
module tb_lap_time_bcd_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        refresh = 1'b0;
    logic [15:0] current_lap_time = '0;
    logic [15:0] last_lap_time = '0;
    logic [15:0] best_lap_time = '0;
    logic [19:0] current_bcd, last_bcd, best_bcd;
    logic        busy, done;

    int total = 0;
    int bad = 0;

    lap_time_bcd_reader dut (
        .clk              (clk),
        .rst              (rst),
        .refresh          (refresh),
        .current_lap_time (current_lap_time),
        .last_lap_time    (last_lap_time),
        .best_lap_time    (best_lap_time),
        .current_bcd      (current_bcd),
        .last_bcd         (last_bcd),
        .best_bcd         (best_bcd),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

`ifdef BLANK_ZERO_EN
    localparam logic [19:0] ExpZero = 20'hFF000;
    localparam logic [19:0] Exp599  = 20'hFF599;
    localparam logic [19:0] Exp1000 = 20'hF1000;
`else
    localparam logic [19:0] ExpZero = 20'h00000;
    localparam logic [19:0] Exp599  = 20'h00599;
    localparam logic [19:0] Exp1000 = 20'h01000;
`endif

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse refresh so that the next edge is E0; returns at E0+1.
    task automatic start_conv();
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        current_lap_time = 16'd111;
        last_lap_time = 16'd222;
        best_lap_time = 16'd333;
        refresh = 1'b1;
        tick(2);
        total++;
        if (current_bcd !== 20'h0 || last_bcd !== 20'h0 || best_bcd !== 20'h0) begin
            bad++;
            $display("FAIL reset_bcd: got %h %h %h want 0 0 0", current_bcd, last_bcd, best_bcd);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        refresh = 1'b0;
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        current_lap_time = 16'd12345;
        last_lap_time = 16'd599;
        best_lap_time = 16'd0;
        start_conv();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_e0: got %b want 1", busy);
        end
        tick(17);
        total++;
        if (current_bcd !== 20'h0) begin
            bad++;
            $display("FAIL basic_cur_e17: got %h want 00000", current_bcd);
        end
        tick(1);
        total++;
        if (current_bcd !== 20'h12345 || last_bcd !== 20'h0) begin
            bad++;
            $display("FAIL basic_e18: got cur=%h last=%h want 12345 00000", current_bcd, last_bcd);
        end
        tick(18);
        total++;
        if (last_bcd !== 20'h00599) begin
            bad++;
            $display("FAIL basic_last_e36: got %h want 00599", last_bcd);
        end
        tick(17);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_e53: got done=%b busy=%b want 0 1", done, busy);
        end
        tick(1);
        total++;
        if (best_bcd !== 20'h0 || done !== 1'b1 || busy !== 1'b0 || current_bcd !== 20'h12345) begin
            bad++;
            $display("FAIL basic_e54: got best=%h done=%b busy=%b cur=%h want 00000 1 0 12345",
                     best_bcd, done, busy, current_bcd);
        end
        tick(1);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_e55: got %b want 0", done);
        end
    endtask

    task automatic test_full_scale();
        current_lap_time = 16'd65535;
        last_lap_time = 16'd65535;
        best_lap_time = 16'd65535;
        start_conv();
        tick(54);
        total++;
        if (current_bcd !== 20'h65535 || last_bcd !== 20'h65535 || best_bcd !== 20'h65535
            || done !== 1'b1) begin
            bad++;
            $display("FAIL max: got %h %h %h done=%b want 65535 x3 done=1",
                     current_bcd, last_bcd, best_bcd, done);
        end
        tick(1);
        current_lap_time = 16'd1000;
        last_lap_time = 16'd1000;
        best_lap_time = 16'd1000;
        start_conv();
        tick(54);
        total++;
        if (current_bcd !== 20'h01000 || last_bcd !== 20'h01000 || best_bcd !== 20'h01000) begin
            bad++;
            $display("FAIL thousand: got %h %h %h want 01000 x3", current_bcd, last_bcd, best_bcd);
        end
        tick(1);
    endtask

    task automatic test_ignore_refresh();
        current_lap_time = 16'd500;
        last_lap_time = 16'd1;
        best_lap_time = 16'd2;
        start_conv();
        tick(2);
        current_lap_time = 16'd42;
        tick(2);
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL ignore_busy_e5: got %b want 1", busy);
        end
        tick(13);
        total++;
        if (current_bcd !== 20'h00500) begin
            bad++;
            $display("FAIL snapshot_e18: got %h want 00500", current_bcd);
        end
        tick(35);
        refresh = 1'b1;
        tick(1);
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL refresh_e54: got busy=%b done=%b want 0 1", busy, done);
        end
        tick(1);
        refresh = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL accept_e55: got busy=%b want 1", busy);
        end
        tick(18);
        total++;
        if (current_bcd !== 20'h00042) begin
            bad++;
            $display("FAIL second_cur: got %h want 00042", current_bcd);
        end
        tick(36);
        total++;
        if (done !== 1'b1 || last_bcd !== 20'h00001 || best_bcd !== 20'h00002) begin
            bad++;
            $display("FAIL second_end: got done=%b last=%h best=%h want 1 00001 00002",
                     done, last_bcd, best_bcd);
        end
        tick(1);
    endtask

    task automatic test_reset_abort();
        int done_seen;
        current_lap_time = 16'd1234;
        last_lap_time = 16'd1234;
        best_lap_time = 16'd1234;
        start_conv();
        tick(24);
        rst = 1'b0;
        tick(1);
        total++;
        if (current_bcd !== 20'h0 || last_bcd !== 20'h0 || best_bcd !== 20'h0
            || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_e25: got %h %h %h busy=%b done=%b want all 0",
                     current_bcd, last_bcd, best_bcd, busy, done);
        end
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", done_seen);
        end
        start_conv();
        tick(54);
        total++;
        if (current_bcd !== 20'h01234 || last_bcd !== 20'h01234 || best_bcd !== 20'h01234
            || done !== 1'b1) begin
            bad++;
            $display("FAIL after_abort: got %h %h %h done=%b want 01234 x3 done=1",
                     current_bcd, last_bcd, best_bcd, done);
        end
        tick(1);
    endtask

    task automatic test_blank();
        current_lap_time = 16'd0;
        last_lap_time = 16'd599;
        best_lap_time = 16'd1000;
        start_conv();
        tick(54);
        total++;
        if (current_bcd !== ExpZero || last_bcd !== Exp599 || best_bcd !== Exp1000) begin
            bad++;
            $display("FAIL blank_small: got %h %h %h want %h %h %h",
                     current_bcd, last_bcd, best_bcd, ExpZero, Exp599, Exp1000);
        end
        tick(1);
        current_lap_time = 16'd12345;
        last_lap_time = 16'd12345;
        best_lap_time = 16'd12345;
        start_conv();
        tick(54);
        total++;
        if (current_bcd !== 20'h12345 || last_bcd !== 20'h12345 || best_bcd !== 20'h12345) begin
            bad++;
            $display("FAIL blank_full: got %h %h %h want 12345 x3", current_bcd, last_bcd, best_bcd);
        end
        tick(1);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_basic();
        test_full_scale();
        test_ignore_refresh();
        test_reset_abort();
        test_blank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
